// File: rtl/execute_divider.sv
// Iterative restoring divider for DIV/DIVU in Execute: one quotient bit per cycle,
// signs handled by dividing magnitudes and negating the results in DONE.
module execute_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_e,
  input  logic             is_signed_e,
  input  logic [WIDTH-1:0] src_a_e,
  input  logic [WIDTH-1:0] src_b_e,
  input  logic             flush_e,
  output logic             stall_div,
  output logic             has_div_e,
  output logic [WIDTH-1:0] div_hi_e,
  output logic [WIDTH-1:0] div_lo_e
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] absB_q, absB_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             negQ_q, negQ_d;
  logic             negR_q, negR_d;

  logic             load;
  logic             lastStep;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;

  // A new request is accepted from IDLE or DONE; a start seen during RUN is the held instruction.
  assign load     = start_e & ~flush_e & (state_q != RUN);
  assign lastStep = (cnt_q == CNT_W'(WIDTH - 1));
  assign absA     = (is_signed_e & src_a_e[WIDTH-1]) ? (-src_a_e) : src_a_e;
  assign absB     = (is_signed_e & src_b_e[WIDTH-1]) ? (-src_b_e) : src_b_e;
  assign remShift = {rem_q, quo_q[WIDTH-1]};
  assign trial    = remShift - {1'b0, absB_q};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_e) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_e) state_d = RUN;
        RUN:     if (lastStep) state_d = DONE;
        DONE:    state_d = start_e ? RUN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    has_div_e = (state_q == DONE);
    div_lo_e  = '0;
    div_hi_e  = '0;
    if (state_q == DONE) begin
      div_lo_e = negQ_q ? (-quo_q) : quo_q;
      div_hi_e = negR_q ? (-rem_q) : rem_q;
    end
    stall_div = ((state_q == IDLE) & start_e) | (state_q == RUN) |
                ((state_q == DONE) & start_e);
  end

  // The dividend magnitude is shifted out of quo as quotient bits are shifted in.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    absB_d = absB_q;
    cnt_d  = cnt_q;
    negQ_d = negQ_q;
    negR_d = negR_q;
    if (load) begin
      rem_d  = '0;
      quo_d  = absA;
      absB_d = absB;
      cnt_d  = '0;
      negQ_d = is_signed_e & (src_a_e[WIDTH-1] ^ src_b_e[WIDTH-1]);
      negR_d = is_signed_e & src_a_e[WIDTH-1];
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + 1'b1;
      quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      rem_d = trial[WIDTH] ? remShift[WIDTH-1:0] : trial[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      absB_q <= '0;
      cnt_q  <= '0;
      negQ_q <= 1'b0;
      negR_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      absB_q <= absB_d;
      cnt_q  <= cnt_d;
      negQ_q <= negQ_d;
      negR_q <= negR_d;
    end
  end

endmodule

// File: tb/tb_execute_divider.sv
// Self-checking bench for execute_divider: directed cases plus randomized operands
// compared against a behavioural model built on Verilog / and %.
module tb_execute_divider;

  localparam int W = 32;

  logic         clock;
  logic         reset;
  logic         startE;
  logic         isSignedE;
  logic [W-1:0] srcAE;
  logic [W-1:0] srcBE;
  logic         flushE;
  logic         stallDiv;
  logic         hasDivE;
  logic [W-1:0] divHiE;
  logic [W-1:0] divLoE;

  int testsRun  = 0;
  int failCount = 0;

  execute_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clock      (clock),
    .reset      (reset),
    .start_e    (startE),
    .is_signed_e(isSignedE),
    .src_a_e    (srcAE),
    .src_b_e    (srcBE),
    .flush_e    (flushE),
    .stall_div  (stallDiv),
    .has_div_e  (hasDivE),
    .div_hi_e   (divHiE),
    .div_lo_e   (divLoE)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // MIPS-style DIV/DIVU result, with the divide-by-zero and overflow cases spelled out.
  function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                 output logic [W-1:0] lo, output logic [W-1:0] hi);
    if (b == '0) begin
      lo = (sgn && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
      hi = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = '0;
    end else if (sgn) begin
      lo = $signed(a) / $signed(b);
      hi = $signed(a) % $signed(b);
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  // Drive a request at the current negedge (cycle T).
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
    startE    = 1'b1;
    isSignedE = sgn;
    srcAE     = a;
    srcBE     = b;
  endtask

  // Walk through cycles T+1..T+W with start held, as the stalled pipeline would.
  task automatic holdRun(input bit full, input string tag);
    for (int k = 1; k <= W; k++) begin
      @(negedge clock);
      #1;
      if (full) begin
        checkOutput({tag, "_stall_run"}, W'(stallDiv), W'(1));
        checkOutput({tag, "_has_run"}, W'(hasDivE), W'(0));
      end else if (k == W) begin
        checkOutput({tag, "_has_early"}, W'(hasDivE), W'(0));
      end
    end
  endtask

  // Full request: start at T, result expected exactly at T+W+1, then back to idle outputs.
  task automatic runDiv(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                        input logic [W-1:0] expLo, input logic [W-1:0] expHi,
                        input string tag, input bit full);
    applyStimulus(a, b, sgn);
    #1;
    checkOutput({tag, "_stall_T"}, W'(stallDiv), W'(1));
    holdRun(full, tag);
    @(negedge clock);
    startE = 1'b0;
    #1;
    checkOutput({tag, "_has"}, W'(hasDivE), W'(1));
    checkOutput({tag, "_lo"}, divLoE, expLo);
    checkOutput({tag, "_hi"}, divHiE, expHi);
    if (full) checkOutput({tag, "_stall_done"}, W'(stallDiv), W'(0));
    @(negedge clock);
    #1;
    if (full) begin
      checkOutput({tag, "_has_after"}, W'(hasDivE), W'(0));
      checkOutput({tag, "_lo_after"}, divLoE, W'(0));
      checkOutput({tag, "_hi_after"}, divHiE, W'(0));
    end
  endtask

  // Watch for a stray has_div_e pulse over a number of cycles.
  task automatic expectNoPulse(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      #1;
      if (hasDivE) seen = 1'b1;
    end
    checkOutput(tag, W'(seen), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b, expLo, expHi;
    logic         sgn;

    reset = 1'b1; startE = 1'b0; isSignedE = 1'b0; srcAE = '0; srcBE = '0; flushE = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_has", W'(hasDivE), W'(0));
    checkOutput("rst_lo", divLoE, W'(0));
    checkOutput("rst_hi", divHiE, W'(0));
    checkOutput("rst_stall", W'(stallDiv), W'(0));
    @(negedge clock);

    runDiv(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "divu_100_7", 1'b1);
    runDiv(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2", 1'b0);
    runDiv(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "div_7_m2", 1'b0);
    runDiv(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, "divu_by0", 1'b0);
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "div_ovf", 1'b0);

    // Reset in the middle of DIVU 50/5 must discard it silently.
    applyStimulus(32'd50, 32'd5, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    startE = 1'b0;
    @(negedge clock);
    #1;
    checkOutput("midrst_stall", W'(stallDiv), W'(0));
    checkOutput("midrst_has", W'(hasDivE), W'(0));
    reset = 1'b0;
    expectNoPulse(40, "midrst_nopulse");
    runDiv(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, "after_rst", 1'b0);

    // Flush at T+5 wins over the still-asserted start.
    applyStimulus(32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clock);
    flushE = 1'b1;
    @(negedge clock);
    flushE = 1'b0;
    startE = 1'b0;
    #1;
    checkOutput("flush_stall", W'(stallDiv), W'(0));
    checkOutput("flush_has", W'(hasDivE), W'(0));
    expectNoPulse(40, "flush_nopulse");

    // Back-to-back: new request launched in the DONE cycle of 20/3.
    applyStimulus(32'd20, 32'd3, 1'b0);
    holdRun(1'b0, "b2b_first");
    @(negedge clock);
    applyStimulus(32'd9, 32'd4, 1'b0);
    #1;
    checkOutput("b2b_first_has", W'(hasDivE), W'(1));
    checkOutput("b2b_first_lo", divLoE, 32'd6);
    checkOutput("b2b_first_hi", divHiE, 32'd2);
    checkOutput("b2b_stall_done", W'(stallDiv), W'(1));
    holdRun(1'b0, "b2b_second");
    @(negedge clock);
    startE = 1'b0;
    #1;
    checkOutput("b2b_second_has", W'(hasDivE), W'(1));
    checkOutput("b2b_second_lo", divLoE, 32'd2);
    checkOutput("b2b_second_hi", divHiE, 32'd1);
    @(negedge clock);

    for (int n = 0; n < 2000; n++) begin
      sgn = 1'(($urandom & 32'h1));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = $urandom_range(0, 15);
        1:       b = -($urandom_range(0, 15));
        2:       begin a = 32'h8000_0000; b = ($urandom & 32'h1) ? 32'hFFFF_FFFF : $urandom; end
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      refDiv(a, b, sgn, expLo, expHi);
      runDiv(a, b, sgn, expLo, expHi, "rand", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
